// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes and FSM state encoding for the ALU micro-sequencer
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_NOP = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SHIFT,
        D_TEST,
        D_EVAL,
        D_SUB,
        DONE
    } state_t;

endpackage

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - micro-sequencer driving ALU strobes for ADD/SUB/CMP/ROR/DIV
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DIV_LIMIT = 255
) (
    input  logic       clk,
    input  logic       resetBar,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] count,
    input  logic       flagCarry,
    input  logic       aIsZero,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic       overflow,
    output logic       doSubtract,
    output logic       assertBarE,
    output logic       assertBarS,
    output logic       triggerC,
    output logic       triggerS,
    output logic       loadA
);

    localparam logic [7:0] LIMIT = 8'(DIV_LIMIT);

    state_t     state, state_next;
    logic [2:0] op_q;
    logic [2:0] cur_op;
    logic [3:0] shift_cnt;
    logic       accept, ovf_set;
    logic       sub_d, be_d, bs_d, tc_d, ts_d, la_d;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) state <= IDLE;
        else           state <= state_next;
    end

    // Outputs are registered, so strobes are decoded from the state being entered.
    always_comb begin
        accept     = start && (state == IDLE || state == DONE);
        cur_op     = accept ? op : op_q;
        state_next = state;
        ovf_set    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_CMP: state_next = EXEC;
                        OP_ROR:                 state_next = SHIFT;
                        OP_DIV:                 state_next = D_TEST;
                        OP_NOP:                 state_next = DONE;
                        default:                state_next = DONE;
                    endcase
                end else begin
                    state_next = IDLE;
                end
            end
            EXEC:   state_next = DONE;
            SHIFT:  if (shift_cnt == 4'd1) state_next = DONE;
            D_TEST: state_next = D_EVAL;
            D_EVAL: begin
                if (aIsZero || !flagCarry) begin
                    state_next = DONE;
                end else if (quotient == LIMIT) begin
                    ovf_set    = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = D_SUB;
                end
            end
            D_SUB:  state_next = D_TEST;
            default: state_next = IDLE;
        endcase

        sub_d = 1'b0;
        be_d  = 1'b1;
        bs_d  = 1'b1;
        tc_d  = 1'b0;
        ts_d  = 1'b0;
        la_d  = 1'b0;
        case (state_next)
            EXEC: begin
                sub_d = (cur_op == OP_CMP) | cur_op[0];
                be_d  = (cur_op == OP_CMP);
                la_d  = (cur_op != OP_CMP);
                tc_d  = 1'b1;
            end
            SHIFT: begin
                bs_d = 1'b0;
                la_d = 1'b1;
                ts_d = 1'b1;
            end
            D_TEST: begin
                sub_d = 1'b1;
                tc_d  = 1'b1;
            end
            D_SUB: begin
                sub_d = 1'b1;
                be_d  = 1'b0;
                la_d  = 1'b1;
                tc_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            op_q       <= OP_ADD;
            shift_cnt  <= 4'd0;
            quotient   <= 8'd0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            doSubtract <= 1'b0;
            assertBarE <= 1'b1;
            assertBarS <= 1'b1;
            triggerC   <= 1'b0;
            triggerS   <= 1'b0;
            loadA      <= 1'b0;
        end else begin
            busy       <= !(state_next == IDLE || state_next == DONE);
            done       <= (state_next == DONE);
            doSubtract <= sub_d;
            assertBarE <= be_d;
            assertBarS <= bs_d;
            triggerC   <= tc_d;
            triggerS   <= ts_d;
            loadA      <= la_d;
            if (accept) begin
                op_q      <= op;
                shift_cnt <= (count == 3'd0) ? 4'd8 : {1'b0, count};
                overflow  <= 1'b0;
                if (op == OP_DIV) quotient <= 8'd0;
            end else begin
                if (state == SHIFT) shift_cnt <= shift_cnt - 4'd1;
                if (state == D_SUB) quotient <= quotient + 8'd1;
                if (ovf_set) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - bench for alu_seq with ALU/A-register plant and trace model
module tb_alu_seq;

    localparam logic [16:0] FULL = 17'h1FFFF;
    localparam logic [16:0] NOQ  = 17'h1FF00;

    logic       clk = 1'b0;
    logic       resetBar = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [2:0] count = 3'd0;
    logic       flagCarry, aIsZero;
    logic       busy, done, overflow, doSubtract, assertBarE, assertBarS;
    logic       triggerC, triggerS, loadA;
    logic [7:0] quotient;

    logic       start3 = 1'b0;
    logic       busy3, done3, ovf3, sub3, be3, bs3, tc3, ts3, la3;
    logic [7:0] q3;

    logic [7:0] env_a = 8'h00, env_b = 8'h00;
    logic       env_c = 1'b0, env_s = 1'b0;
    logic       ld_req = 1'b0;
    logic [7:0] ld_a = 8'h00, ld_b = 8'h00;
    logic       ld_c = 1'b0, ld_s = 1'b0;

    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_q = 8'h00;
    logic       m_c = 1'b0, m_s = 1'b0, m_ovf = 1'b0;
    logic [16:0] exp_v[$];
    logic [16:0] exp_m[$];
    logic        chk_en = 1'b0;
    int          checks = 0, errors = 0;
    logic [16:0] act;

    alu_seq dut (
        .clk(clk), .resetBar(resetBar), .start(start), .op(op), .count(count),
        .flagCarry(flagCarry), .aIsZero(aIsZero), .busy(busy), .done(done),
        .quotient(quotient), .overflow(overflow), .doSubtract(doSubtract),
        .assertBarE(assertBarE), .assertBarS(assertBarS), .triggerC(triggerC),
        .triggerS(triggerS), .loadA(loadA)
    );

    alu_seq #(.DIV_LIMIT(3)) dut3 (
        .clk(clk), .resetBar(resetBar), .start(start3), .op(3'd4), .count(3'd0),
        .flagCarry(1'b1), .aIsZero(1'b0), .busy(busy3), .done(done3),
        .quotient(q3), .overflow(ovf3), .doSubtract(sub3),
        .assertBarE(be3), .assertBarS(bs3), .triggerC(tc3),
        .triggerS(ts3), .loadA(la3)
    );

    always #5 clk = ~clk;

    assign flagCarry = env_c;
    assign aIsZero   = (env_a == 8'h00);
    assign act = {busy, done, doSubtract, assertBarE, assertBarS, triggerC, triggerS, loadA,
                  overflow, quotient};

    // Plant: adder, shifter, A register and the two flags the sequencer controls.
    always @(posedge clk) begin : plant
        logic [8:0] sum;
        logic [7:0] bus;
        sum = doSubtract ? ({1'b0, env_a} + {1'b0, ~env_b} + 9'd1)
                         : ({1'b0, env_a} + {1'b0, env_b});
        if (!assertBarE)      bus = sum[7:0];
        else if (!assertBarS) bus = {env_s, env_a[7:1]};
        else                  bus = 8'h00;
        if (ld_req) begin
            env_a <= ld_a;
            env_b <= ld_b;
            env_c <= ld_c;
            env_s <= ld_s;
        end else begin
            if (loadA)    env_a <= bus;
            if (triggerC) env_c <= sum[8];
            if (triggerS) env_s <= env_a[0];
        end
    end

    function automatic logic [16:0] ev(input logic bz, dn, sb, be, bs, tc, ts, la);
        return {bz, dn, sb, be, bs, tc, ts, la, m_ovf, m_q};
    endfunction

    task automatic push(input logic [16:0] v, input logic [16:0] m);
        exp_v.push_back(v);
        exp_m.push_back(m);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [16:0] e, m;
        if (resetBar && chk_en) begin
            if (exp_v.size() > 0) begin
                e = exp_v.pop_front();
                m = exp_m.pop_front();
            end else begin
                e = ev(0, 0, 0, 1, 1, 0, 0, 0);
                m = FULL;
            end
            checks++;
            if ((act & m) !== (e & m)) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got %h expected %h mask %h", $time, act, e, m);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [2:0] c, input bit load,
                         input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sin);
        int n;
        logic [8:0] v;
        bit first;
        if (load) begin
            ld_req = 1'b1; ld_a = a; ld_b = b; ld_c = cin; ld_s = sin;
            m_a = a; m_b = b; m_c = cin; m_s = sin;
        end
        start = 1'b1;
        op    = o;
        count = c;
        m_ovf = 1'b0;
        if (o == 3'd0) begin
            push(ev(1, 0, 0, 0, 1, 1, 0, 1), FULL);
            {m_c, m_a} = {1'b0, m_a} + {1'b0, m_b};
        end else if (o == 3'd1) begin
            push(ev(1, 0, 1, 0, 1, 1, 0, 1), FULL);
            m_c = (m_a >= m_b);
            m_a = m_a - m_b;
        end else if (o == 3'd2) begin
            push(ev(1, 0, 1, 1, 1, 1, 0, 0), FULL);
            m_c = (m_a >= m_b);
        end else if (o == 3'd3) begin
            n = (c == 3'd0) ? 8 : int'(c);
            v = {m_s, m_a};
            for (int k = 0; k < n; k++) begin
                push(ev(1, 0, 0, 1, 0, 0, 1, 1), FULL);
                v = {v[0], v[8:1]};
            end
            {m_s, m_a} = v;
        end else if (o == 3'd4) begin
            m_q = 8'd0;
            first = 1'b1;
            while (1) begin
                push(ev(1, 0, 1, 1, 1, 1, 0, 0), first ? FULL : NOQ);
                first = 1'b0;
                m_c = (m_a >= m_b);
                push(ev(1, 0, 0, 1, 1, 0, 0, 0), NOQ);
                if (m_a == 8'd0 || !m_c) break;
                if (m_q == 8'd255) begin
                    m_ovf = 1'b1;
                    break;
                end
                push(ev(1, 0, 1, 0, 1, 1, 0, 1), NOQ);
                m_a = m_a - m_b;
                m_q = m_q + 8'd1;
            end
        end
        push(ev(0, 1, 0, 1, 1, 0, 0, 0), FULL);
        @(posedge clk);
        #1;
        start  = 1'b0;
        ld_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_v.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", exp_v.size(), 0);
        exp_v.delete();
        exp_m.delete();
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0] ro, rc;
        logic [7:0] ra, rb;
        bit rl;

        #2 resetBar = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", act, 17'h03000);
        chk("reset_outputs_lim3", {busy3, done3, ovf3, q3, be3, bs3}, 13'h0003);
        resetBar = 1'b1;
        chk_en   = 1'b1;
        gap(2);

        issue(3'd0, 3'd0, 1, 8'h3C, 8'h05, 0, 0);
        chk("add_model", m_a, 8'h41);
        wait_idle();
        chk("add_a", env_a, 8'h41);
        chk("add_c", env_c, 0);
        gap(1);

        issue(3'd1, 3'd0, 1, 8'h05, 8'h07, 0, 0);
        wait_idle();
        chk("sub_a", env_a, 8'hFE);
        chk("sub_c", env_c, 0);
        issue(3'd2, 3'd0, 1, 8'h07, 8'h07, 0, 0);
        wait_idle();
        chk("cmp_a", env_a, 8'h07);
        chk("cmp_c", env_c, 1);
        gap(3);

        issue(3'd3, 3'd3, 1, 8'h0B, 8'h00, 0, 0);
        chk("ror3_model", m_a, 8'hC1);
        wait_idle();
        chk("ror3_a", env_a, 8'hC1);
        chk("ror3_s", env_s, 0);
        issue(3'd3, 3'd0, 0, 8'h00, 8'h00, 0, 0);
        chk("ror8_len", exp_v.size(), 9);
        wait_idle();
        chk("ror8_a", env_a, 8'h82);
        chk("ror8_s", env_s, 1);
        gap(2);

        issue(3'd4, 3'd0, 1, 8'd100, 8'd7, 0, 0);
        chk("div_len", exp_v.size(), 45);
        gap(4);
        start = 1'b1;
        op    = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("div_q", quotient, 8'd14);
        chk("div_rem", env_a, 8'd2);
        chk("div_ovf", overflow, 0);
        gap(2);

        issue(3'd4, 3'd0, 1, 8'd0, 8'd0, 0, 0);
        chk("div00_len", exp_v.size(), 3);
        wait_idle();
        chk("div00_q", quotient, 8'd0);

        issue(3'd4, 3'd0, 1, 8'd5, 8'd0, 0, 0);
        chk("div50_len", exp_v.size(), 768);
        wait_idle();
        chk("div50_ovf", overflow, 1);
        chk("div50_q", quotient, 8'd255);
        gap(2);

        @(negedge clk);
        #1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        n = 1;
        while (!done3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lim3_done_cycle", n, 12);
        chk("lim3_q", q3, 8'd3);
        chk("lim3_ovf", ovf3, 1);
        chk("lim3_strobes", {sub3, be3, bs3, tc3, ts3, la3, busy3}, 7'b0110000);
        gap(2);

        issue(3'd4, 3'd0, 1, 8'd100, 8'd7, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        resetBar = 1'b0;
        exp_v.delete();
        exp_m.delete();
        m_q   = 8'd0;
        m_ovf = 1'b0;
        #1;
        chk("abort_outputs", act, 17'h03000);
        repeat (2) @(negedge clk);
        #1;
        resetBar = 1'b1;
        gap(3);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rc = 3'($urandom_range(0, 7));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 9) == 0) begin
                ra = 8'd0;
                rb = 8'd0;
            end
            rl = (i == 0) || ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
            issue(ro, rc, rl, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle();
            chk("rand_a", env_a, m_a);
            chk("rand_c", env_c, m_c);
            chk("rand_s", env_s, m_s);
        end
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Micro-sequencer that drives the 8-bit ALU datapath's control strobes (`doSubtract`, `assertBarE`, `assertBarS`, `triggerC`, `triggerS`) plus the A-register load enable, so that one `start` request runs a complete operation. Single-cycle ops are ADD, SUB, CMP. Multi-cycle ops are rotate-through-shift-flag by N, and unsigned DIV by repeated subtraction. It sits between the instruction decoder and the ALU/A-register, and owns all ALU strobes.

## Interface
- `DIV_LIMIT`, 255: maximum quotient before DIV aborts with overflow.

- `clk`  in  1  system clock.
- `resetBar`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  3  0 ADD, 1 SUB, 2 CMP, 3 ROR, 4 DIV, 5–7 NOP.
- `count`  in  3  ROR shift count; 0 encodes 8.
- `flagCarry`  in  1  ALU carry flag.
- `aIsZero`  in  1  A-register zero detect.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `quotient`  out  8  DIV result.
- `overflow`  out  1  DIV hit `DIV_LIMIT`.
- `doSubtract`, `triggerC`, `triggerS`, `loadA`  out  1 each  active-high ALU strobes.
- `assertBarE`, `assertBarS`  out  1 each  active-low bus drives for the adder and shifter.

## Operation
- All outputs are registered.
- Reset values:
  - `assertBarE`=`assertBarS`=1.
  - All other outputs 0.
  - State IDLE.
- Integration rule: `triggerC`, `triggerS` and `loadA` are synchronous enables. The flag and A-register update on the `clk` edge that ends the cycle in which the strobe is high.
- `assertBarE` and `assertBarS` are never both 0.
- States: IDLE, EXEC, SHIFT, D_TEST, D_EVAL, D_SUB, DONE.
- Accept: `start`=1 in IDLE or DONE latches `op`, `count`, and clears `overflow`. DIV also clears `quotient`.
- ADD/SUB → EXEC, then DONE.
  - EXEC: `doSubtract`=op[0], `assertBarE`=0, `loadA`=1, `triggerC`=1.
- CMP → EXEC with `doSubtract`=1, `triggerC`=1, no bus drive, `loadA`=0.
- ROR → N SHIFT cycles, then DONE.
  - Each SHIFT: `assertBarS`=0, `loadA`=1, `triggerS`=1.
  - Effect: 9-bit rotate right through the shift flag.
- DIV → D_TEST: `doSubtract`=1, `triggerC`=1, no write.
- D_EVAL: all strobes idle.
  - `aIsZero`=1 or `flagCarry`=0 → DONE.
  - Else `quotient`==`DIV_LIMIT` → `overflow`=1, DONE.
  - Else → D_SUB.
- D_SUB: SUB-write strobes as EXEC; `quotient`+1; → D_TEST.
- Result: A holds the remainder, `quotient` the quotient.
- DONE: `done`=1, `busy`=0, strobes idle; → IDLE unless a new start is accepted.
- NOP: accepted → DONE next cycle, no strobes.
- `start` while `busy`=1 is ignored, not queued.
- `resetBar` low mid-operation: immediate abort to reset values, no `done`.
- `quotient` holds until the next DIV accept or reset. `quotient` arithmetic is 8-bit and never wraps, because the limit check precedes the increment.

## Timing
- Start is sampled at edge 0; cycle k is the cycle after edge k-1.
- ADD/SUB/CMP: strobes in cycle 1, `done` in cycle 2.
- ROR N: SHIFT in cycles 1..N, `done` in cycle N+1.
- DIV with quotient q, no overflow: active cycles 1..3q+2, `done` in cycle 3q+3.
- `busy`=1 from cycle 1 through the last active cycle.
- Back-to-back: start in the DONE cycle begins the next op in the following cycle; no idle gap.

## Structure
- `alu_seq_pkg`: op-code constants (OP_ADD…OP_NOP) and the state enum.
- No sub-module: the FSM, `quotient` counter and shift counter are all inline.

## Test plan
- ADD, A=0x3C, B=0x05 → cycle 1: `doSubtract`=0, `assertBarE`=0, `loadA`=1, `triggerC`=1; `done` cycle 2; A=0x41, carry 0.
- SUB, A=0x05, B=0x07 → A=0xFE, carry 0. Then CMP, A=0x07, B=0x07 → carry 1, A unchanged, `loadA` never high.
- ROR `count`=3, A=0x0B, shift flag 0 → SHIFT in cycles 1–3; A=0xC1, flag 0; `done` cycle 4. `count`=0 → 8 SHIFT cycles.
- DIV, A=100, B=7 → `quotient`=14, A=2, `overflow`=0, `done` cycle 45. DIV, A=0, B=0 → `quotient`=0, `done` cycle 3.
- DIV, A=5, B=0 → `overflow`=1, `quotient`=255. Retest with `DIV_LIMIT`=3 → `quotient`=3, `overflow`=1.
- `start` pulsed during busy → ignored. `resetBar` low in D_SUB → all outputs at reset values, no `done`. Start in DONE cycle → next EXEC one cycle later.
